branch_flush_controller: RTL and testbench

- Sequences control-flow redirects for the pipelined Goldcrest core.
- Holds a direct-mapped table of 2-bit saturating branch-history counters and gives fetch a taken/not-taken prediction.
- Takes the resolved branch decision (pcsel-equivalent) from EX and compares it with the prediction carried down the pipe.
- On a mispredict or jump, issues a handshaked PC redirect to fetch and holds the front-end flush until the redirect is accepted plus a programmable drain period.

---
 rtl/branch_flush_controller.sv | 137 +++++++++++++
 tb/tb_branch_flush_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_flush_controller.sv
// Branch predictor table plus mispredict redirect/flush sequencer for the
// Goldcrest front-end: predicts at fetch, resolves at EX, redirects and drains.
module branch_flush_controller #(
  parameter int XLEN         = 32,
  parameter int IDX_W        = 6,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_jb,
  input  logic             ex_bc,
  input  logic             ex_taken,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } state_t;

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

  state_t state, state_nx;
  logic [2:0] cnt;
  logic [1:0] bht [DEPTH];
  logic [1:0] bht_cur, bht_nx;
  logic accept, upd, redir;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [XLEN-1:0] tgt;
  logic unused_bits;

  assign unused_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                         ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  assign rd_idx = if_pc[IDX_W+1:2];
  assign wr_idx = ex_pc[IDX_W+1:2];
  assign if_pred_taken = bht[rd_idx][1];
  assign bht_cur = bht[wr_idx];

  always_comb begin
    state_nx       = state;
    accept         = 1'b0;
    upd            = 1'b0;
    redir          = 1'b0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    unique case (state)
      IDLE: begin
        accept = ex_valid & (ex_jb | ex_bc);
        upd    = accept & ex_bc & ~ex_jb;
        redir  = accept &
                 (ex_jb | (ex_bc & (ex_taken != ex_pred_taken)));
        if (redir) state_nx = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        flush          = 1'b1;
        if (redirect_ready) state_nx = FLUSH;
      end
      FLUSH: begin
        flush = 1'b1;
        if (cnt == 3'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tgt = ex_target;
    if (!(ex_jb || ex_taken)) tgt = ex_pc + XLEN'(4);
  end

  // Two-bit saturating update of the entry being resolved
  always_comb begin
    bht_nx = bht_cur;
    if (ex_taken) begin
      if (bht_cur != 2'b11) bht_nx = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_nx = bht_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 3'd0;
    end else if (state == REDIRECT && redirect_ready) begin
      cnt <= FC;
    end else if (state == FLUSH) begin
      cnt <= cnt - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc      <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (accept) branch_count <= branch_count + CNT_W'(1);
      if (redir) begin
        redirect_pc      <= tgt;
        mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bht[i] <= 2'b01;
    end else if (upd) begin
      bht[wr_idx] <= bht_nx;
    end
  end

endmodule

// File: tb/tb_branch_flush_controller.sv
// Directed bench for branch_flush_controller: redirect scoreboard per
// instance plus direct checks of flush timing, counters and predictions.
module tb_branch_flush_controller;

  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] a_if_pc, a_ex_pc, a_ex_target, a_redirect_pc;
  logic [31:0] a_branch_count, a_mispredict_count;
  logic a_if_pred_taken, a_ex_valid, a_ex_jb, a_ex_bc, a_ex_taken;
  logic a_ex_pred_taken, a_redirect_valid, a_redirect_ready, a_flush;

  logic [31:0] b_if_pc, b_ex_pc, b_ex_target, b_redirect_pc;
  logic [31:0] b_branch_count, b_mispredict_count;
  logic b_if_pred_taken, b_ex_valid, b_ex_jb, b_ex_bc, b_ex_taken;
  logic b_ex_pred_taken, b_redirect_valid, b_redirect_ready, b_flush;

  int checks = 0;
  int errors = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 clk = ~clk;

  branch_flush_controller #(.FLUSH_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst),
    .if_pc(a_if_pc), .if_pred_taken(a_if_pred_taken),
    .ex_valid(a_ex_valid), .ex_jb(a_ex_jb), .ex_bc(a_ex_bc),
    .ex_taken(a_ex_taken), .ex_pred_taken(a_ex_pred_taken),
    .ex_pc(a_ex_pc), .ex_target(a_ex_target),
    .redirect_valid(a_redirect_valid), .redirect_pc(a_redirect_pc),
    .redirect_ready(a_redirect_ready), .flush(a_flush),
    .branch_count(a_branch_count),
    .mispredict_count(a_mispredict_count)
  );

  branch_flush_controller #(.FLUSH_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst),
    .if_pc(b_if_pc), .if_pred_taken(b_if_pred_taken),
    .ex_valid(b_ex_valid), .ex_jb(b_ex_jb), .ex_bc(b_ex_bc),
    .ex_taken(b_ex_taken), .ex_pred_taken(b_ex_pred_taken),
    .ex_pc(b_ex_pc), .ex_target(b_ex_target),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .redirect_ready(b_redirect_ready), .flush(b_flush),
    .branch_count(b_branch_count),
    .mispredict_count(b_mispredict_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_ev(input logic jb, input logic bc, input logic tk,
                      input logic pt, input logic [31:0] pc,
                      input logic [31:0] tg);
    a_ex_valid = 1'b1; a_ex_jb = jb; a_ex_bc = bc;
    a_ex_taken = tk; a_ex_pred_taken = pt;
    a_ex_pc = pc; a_ex_target = tg;
  endtask

  // Redirect monitors: each accepted handshake must match the next expected PC
  always @(negedge clk) begin
    if (!rst && a_redirect_valid && a_redirect_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_redirect", a_redirect_pc, 32'hffff_ffff);
      end else begin
        chk("a_redirect_pc", a_redirect_pc, qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_redirect_valid && b_redirect_ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_redirect", b_redirect_pc, 32'hffff_ffff);
      end else begin
        chk("b_redirect_pc", b_redirect_pc, qb.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    a_if_pc = 32'h100; a_ex_valid = 0; a_ex_jb = 0; a_ex_bc = 0;
    a_ex_taken = 0; a_ex_pred_taken = 0; a_ex_pc = 0; a_ex_target = 0;
    a_redirect_ready = 0;
    b_if_pc = 32'h100; b_ex_valid = 0; b_ex_jb = 0; b_ex_bc = 0;
    b_ex_taken = 0; b_ex_pred_taken = 0; b_ex_pc = 0; b_ex_target = 0;
    b_redirect_ready = 0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_pred", 32'(a_if_pred_taken), 0);
    chk("rst_rv", 32'(a_redirect_valid), 0);
    chk("rst_flush", 32'(a_flush), 0);
    chk("rst_rpc", a_redirect_pc, 0);
    chk("rst_bcnt", a_branch_count, 0);
    chk("rst_mcnt", a_mispredict_count, 0);

    // Mispredicted taken branch at 0x40
    a_ev(0, 1, 1, 0, 32'h40, 32'h80);
    qa.push_back(32'h80);
    tick();
    a_ex_valid = 0; a_redirect_ready = 1;
    chk("t1_rv", 32'(a_redirect_valid), 1);
    chk("t1_rpc", a_redirect_pc, 32'h80);
    chk("t1_flush", 32'(a_flush), 1);
    chk("t1_mcnt", a_mispredict_count, 1);
    chk("t1_bcnt", a_branch_count, 1);
    tick();
    a_redirect_ready = 0;
    chk("t2_flush", 32'(a_flush), 1);
    chk("t2_rv", 32'(a_redirect_valid), 0);
    tick();
    chk("t3_flush", 32'(a_flush), 0);
    a_if_pc = 32'h40; #1;
    chk("bht16_taken", 32'(a_if_pred_taken), 1);

    // Jump held off by fetch; wrong-path branch must be ignored
    a_ev(1, 0, 1, 0, 32'h200, 32'h400);
    qa.push_back(32'h400);
    tick();
    a_ev(0, 1, 0, 1, 32'h40, 32'h999);
    for (int i = 0; i < 3; i++) begin
      chk("hold_rv", 32'(a_redirect_valid), 1);
      chk("hold_rpc", a_redirect_pc, 32'h400);
      chk("hold_bcnt", a_branch_count, 2);
      tick();
    end
    a_ex_valid = 0; a_redirect_ready = 1;
    chk("hold_mcnt", a_mispredict_count, 2);
    tick();
    a_redirect_ready = 0;
    tick();
    chk("jmp_idle_flush", 32'(a_flush), 0);
    chk("wrongpath_bht", 32'(a_if_pred_taken), 1);
    a_if_pc = 32'h200; #1;
    chk("jmp_no_bht", 32'(a_if_pred_taken), 0);

    // Ten correctly-predicted not-taken branches at 0x10
    a_if_pc = 32'h10;
    a_ev(0, 1, 0, 0, 32'h10, 32'h900);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("nt_rv", 32'(a_redirect_valid), 0);
    end
    a_ex_valid = 0;
    chk("nt_pred", 32'(a_if_pred_taken), 0);
    chk("nt_bcnt", a_branch_count, 12);
    chk("nt_mcnt", a_mispredict_count, 2);

    // Four taken branches: first mispredicts, counter 0->1->2->3->3
    a_ev(0, 1, 1, 0, 32'h10, 32'h90);
    qa.push_back(32'h90);
    tick();
    a_ex_valid = 0; a_redirect_ready = 1;
    chk("tk1_pred", 32'(a_if_pred_taken), 0);
    tick();
    a_redirect_ready = 0;
    tick();
    a_ev(0, 1, 1, 1, 32'h10, 32'h90);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tk_pred", 32'(a_if_pred_taken), 1);
      chk("tk_rv", 32'(a_redirect_valid), 0);
    end
    a_ex_valid = 0;

    // Not-taken from saturated 3 -> 2, still predicts taken
    a_ev(0, 1, 0, 1, 32'h10, 32'h90);
    qa.push_back(32'h14);
    tick();
    a_ex_valid = 0; a_redirect_ready = 1;
    chk("sat_rpc", a_redirect_pc, 32'h14);
    tick();
    a_redirect_ready = 0;
    tick();
    chk("sat_pred", 32'(a_if_pred_taken), 1);
    chk("sat_bcnt", a_branch_count, 17);
    chk("sat_mcnt", a_mispredict_count, 4);

    // FLUSH_CYCLES=3: mispredicted not-taken at 0x3C, immediate ready
    b_ex_valid = 1; b_ex_bc = 1; b_ex_taken = 0; b_ex_pred_taken = 1;
    b_ex_pc = 32'h3c; b_ex_target = 32'h999; b_redirect_ready = 1;
    qb.push_back(32'h40);
    tick();
    b_ex_valid = 0;
    chk("b_rv", 32'(b_redirect_valid), 1);
    chk("b_rpc", b_redirect_pc, 32'h40);
    chk("b_flush0", 32'(b_flush), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_flush", 32'(b_flush), 1);
      chk("b_rv_low", 32'(b_redirect_valid), 0);
    end
    tick();
    chk("b_flush_end", 32'(b_flush), 0);

    // Reset asserted in the middle of FLUSH
    b_ex_valid = 1; b_ex_jb = 1; b_ex_bc = 0;
    b_ex_pc = 32'h3c; b_ex_target = 32'h500;
    qb.push_back(32'h500);
    tick();
    b_ex_valid = 0; b_ex_jb = 0;
    tick();
    b_redirect_ready = 0;
    tick();
    chk("b_mid_flush", 32'(b_flush), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_flush", 32'(b_flush), 0);
    chk("rr_rv", 32'(b_redirect_valid), 0);
    chk("rr_bcnt", b_branch_count, 0);
    chk("rr_mcnt", b_mispredict_count, 0);
    chk("rr_a_bcnt", a_branch_count, 0);
    a_if_pc = 32'h40; #1;
    chk("rr_bht", 32'(a_if_pred_taken), 0);
    tick();
    chk("rr_flush2", 32'(b_flush), 0);

    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
